rcc_cpu_lp_mode_ctrl: RTL

//  Per-core low-power mode sequencer, one instance per CPU (c1, c2), directly upstream of the kernel clock gate blocks.

---
 rtl/rcc_cpu_lp_mode_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/rcc_cpu_lp_mode_ctrl.sv
// Per-core low-power mode sequencer: turns WFI/SLEEPDEEP into cX_sleep /
// cX_deepsleep levels and orders deep-sleep entry/exit vs. the oscillator.
//
// Ports:
//   sys_clk, sys_rst_n  : clock, async active-low reset
//   cpu_sleeping        : core halted in WFI/WFE
//   cpu_sleepdeep       : core SLEEPDEEP request
//   cpu_wakeup          : wakeup event pending (level)
//   bus_idle            : core-domain bus masters idle
//   osc_rdy             : kernel oscillator stable
//   osc_timeout_clr     : clears the sticky osc_timeout flag
//   c_sleep             : cX_sleep to the gate logic
//   c_deepsleep         : cX_deepsleep to the gate logic
//   osc_off_req         : oscillator power-down request
//   cpu_clk_en          : core clock enable
//   lp_state            : current state code
//   entry_abort         : 1-cycle pulse, deep-sleep entry aborted
//   osc_timeout         : sticky, exit completed on timeout
module rcc_cpu_lp_mode_ctrl #(
    parameter int ENTRY_HOLD  = 4,
    parameter int OSC_TIMEOUT = 1024
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       cpu_sleeping,
    input  logic       cpu_sleepdeep,
    input  logic       cpu_wakeup,
    input  logic       bus_idle,
    input  logic       osc_rdy,
    input  logic       osc_timeout_clr,
    output logic       c_sleep,
    output logic       c_deepsleep,
    output logic       osc_off_req,
    output logic       cpu_clk_en,
    output logic [2:0] lp_state,
    output logic       entry_abort,
    output logic       osc_timeout
);

    localparam int CNT_MAX =
        (ENTRY_HOLD > OSC_TIMEOUT) ? ENTRY_HOLD : OSC_TIMEOUT;
    localparam int CNT_W = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(ENTRY_HOLD - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(OSC_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_SLEEP     = 3'd1,
        ST_DS_ENTRY  = 3'd2,
        ST_DS_GATE   = 3'd3,
        ST_DEEPSLEEP = 3'd4,
        ST_DS_EXIT   = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             abort_nxt;
    logic             tmo_set;

    // Saturating increment: the counter never wraps.
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        abort_nxt = 1'b0;
        tmo_set   = 1'b0;
        case (state)
            ST_RUN: begin
                if (!cpu_wakeup && cpu_sleeping) begin
                    if (cpu_sleepdeep) begin
                        state_nxt = ST_DS_ENTRY;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = ST_SLEEP;
                    end
                end
            end
            ST_SLEEP: begin
                if (cpu_wakeup || !cpu_sleeping)
                    state_nxt = ST_RUN;
            end
            ST_DS_ENTRY: begin
                // Abort outranks the commit on the same cycle.
                if (cpu_wakeup || !cpu_sleeping) begin
                    state_nxt = ST_RUN;
                    abort_nxt = 1'b1;
                end else if (bus_idle) begin
                    if (cnt == HOLD_LAST)
                        state_nxt = ST_DS_GATE;
                    else
                        cnt_nxt = cnt_inc;
                end else begin
                    cnt_nxt = '0;
                end
            end
            ST_DS_GATE: begin
                state_nxt = ST_DEEPSLEEP;
            end
            ST_DEEPSLEEP: begin
                if (cpu_wakeup) begin
                    state_nxt = ST_DS_EXIT;
                    cnt_nxt   = '0;
                end
            end
            ST_DS_EXIT: begin
                cnt_nxt = cnt_inc;
                if (osc_rdy) begin
                    state_nxt = ST_RUN;
                end else if (cnt == TMO_LAST) begin
                    state_nxt = ST_RUN;
                    tmo_set   = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Outputs are decoded from the next state so they switch on the
    // same edge as the state register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= ST_RUN;
            cnt         <= '0;
            c_sleep     <= 1'b0;
            c_deepsleep <= 1'b0;
            osc_off_req <= 1'b0;
            cpu_clk_en  <= 1'b1;
            entry_abort <= 1'b0;
            osc_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            c_sleep     <= (state_nxt != ST_RUN);
            c_deepsleep <= (state_nxt == ST_DS_GATE)
                        || (state_nxt == ST_DEEPSLEEP)
                        || (state_nxt == ST_DS_EXIT);
            osc_off_req <= (state_nxt == ST_DEEPSLEEP);
            cpu_clk_en  <= (state_nxt == ST_RUN);
            entry_abort <= abort_nxt;
            osc_timeout <= tmo_set
                        || (osc_timeout && !osc_timeout_clr);
        end
    end

    assign lp_state = state;

endmodule
